// File: rtl/mfp_als_spi_sampler.sv
// rtl/mfp_als_spi_sampler.sv - PMOD ALS SPI conversion sequencer with periodic/software triggers
module mfp_als_spi_sampler #(
    parameter int SCK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int CS_SETUP      = 2,
    parameter int CS_QUIET      = 4
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       auto_en,
    input  logic       start_req,
    output logic       SPI_CS,
    output logic       SPI_SCK,
    input  logic       SPI_SDO,
    output logic [7:0] value,
    output logic       valid,
    output logic       busy,
    output logic       overrun
);
    localparam int CNT_MAX = (SCK_DIV > CS_SETUP) ? ((SCK_DIV > CS_QUIET) ? SCK_DIV : CS_QUIET)
                                                  : ((CS_SETUP > CS_QUIET) ? CS_SETUP : CS_QUIET);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(SAMPLE_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   tick, tick_nx;
    logic [5:0]         edge_cnt, edge_nx;
    logic [15:0]        shreg, shreg_nx, shifted;
    logic               cs_nx, sck_nx, valid_nx, overrun_nx, pending, pending_nx;
    logic [7:0]         value_nx;
    logic [PER_W-1:0]   per_cnt;
    logic               sdo_q1, sdo_q2;
    logic               auto_tc, req, take;

    assign auto_tc = auto_en && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign req     = auto_tc | start_req;
    assign take    = (state == IDLE) && pending;
    assign busy    = (state != IDLE);
    assign shifted = {shreg[14:0], sdo_q2};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            per_cnt <= '0;
            sdo_q1  <= 1'b0;
            sdo_q2  <= 1'b0;
        end else begin
            sdo_q1 <= SPI_SDO;
            sdo_q2 <= sdo_q1;
            if (!auto_en || auto_tc) per_cnt <= '0;
            else                     per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            tick     <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            SPI_CS   <= 1'b1;
            SPI_SCK  <= 1'b1;
            value    <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            state    <= state_nx;
            tick     <= tick_nx;
            edge_cnt <= edge_nx;
            shreg    <= shreg_nx;
            SPI_CS   <= cs_nx;
            SPI_SCK  <= sck_nx;
            value    <= value_nx;
            valid    <= valid_nx;
            overrun  <= overrun_nx;
            pending  <= pending_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        tick_nx    = tick;
        edge_nx    = edge_cnt;
        shreg_nx   = shreg;
        cs_nx      = SPI_CS;
        sck_nx     = SPI_SCK;
        value_nx   = value;
        valid_nx   = 1'b0;
        overrun_nx = 1'b0;
        pending_nx = pending;

        // The slot frees up in the cycle it is taken, so a request then refills it.
        if (take)       pending_nx = req;
        else if (req) begin
            pending_nx = 1'b1;
            overrun_nx = pending;
        end

        case (state)
            IDLE: begin
                if (pending) begin
                    state_nx = SETUP;
                    tick_nx  = '0;
                    cs_nx    = 1'b0;
                    sck_nx   = 1'b1;
                end
            end
            SETUP: begin
                if (tick == CNT_W'(CS_SETUP - 1)) begin
                    state_nx = SHIFT;
                    tick_nx  = '0;
                    edge_nx  = '0;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            SHIFT: begin
                if (tick == CNT_W'(SCK_DIV - 1)) begin
                    tick_nx = '0;
                    edge_nx = edge_cnt + 1'b1;
                    sck_nx  = ~SPI_SCK;
                    // edge_cnt odd means the edge now issued is even, i.e. rising
                    if (edge_cnt[0]) shreg_nx = shifted;
                    if (edge_cnt == 6'd31) begin
                        value_nx = shifted[12:5];
                        valid_nx = 1'b1;
                        cs_nx    = 1'b1;
                        state_nx = QUIET;
                    end
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            QUIET: begin
                if (tick == CNT_W'(CS_QUIET - 1)) begin
                    state_nx = IDLE;
                    tick_nx  = '0;
                end else begin
                    tick_nx = tick + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mfp_als_spi_sampler.sv
// tb/tb_mfp_als_spi_sampler.sv - scoreboard bench for the ALS SPI sampler
module tb_mfp_als_spi_sampler;
    localparam int SCK_DIV       = 25;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int CS_SETUP      = 2;
    localparam int CS_QUIET      = 4;
    localparam int LATENCY       = 1 + CS_SETUP + 32 * SCK_DIV;

    logic       HCLK = 1'b0, HRESETn = 1'b0, auto_en = 1'b0, start_req = 1'b0, SPI_SDO = 1'b0;
    logic       SPI_CS, SPI_SCK, valid, busy, overrun;
    logic [7:0] value;

    int checks = 0, failures = 0;
    logic [7:0] sb[$];

    mfp_als_spi_sampler #(
        .SCK_DIV(SCK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .CS_SETUP(CS_SETUP), .CS_QUIET(CS_QUIET)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .auto_en(auto_en), .start_req(start_req),
        .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_SDO(SPI_SDO),
        .value(value), .valid(valid), .busy(busy), .overrun(overrun)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ADC model: 3 leading zeros, 8 data bits, 5 trailing zeros, driven on SCK falling edges
    logic [7:0]  model_data = 8'h00;
    logic        ramp = 1'b0;
    logic [15:0] word = 16'h0;
    int          bit_idx = 15;

    always @(negedge SPI_CS) begin
        word    = {3'b000, model_data, 5'b00000};
        bit_idx = 15;
        SPI_SDO = 1'b0;
        if (ramp) model_data = model_data + 8'd1;
    end

    always @(negedge SPI_SCK) begin
        if (!SPI_CS && bit_idx >= 0) begin
            SPI_SDO = word[bit_idx];
            bit_idx--;
        end
    end

    // Frame monitor and scoreboard
    int   cyc = 0, frames = 0, cs_low = 0, cs_high = 0, sck_edges = 0;
    int   last_cs_low = 0, last_edges = 0, last_gap = 0;
    int   valid_cnt = 0, ovr_cnt = 0, last_valid_cyc = 0, interval = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b1;

    always @(negedge HCLK) begin
        cyc++;
        if (prev_cs && !SPI_CS) begin
            frames++;
            cs_low    = 1;
            sck_edges = 0;
            last_gap  = cs_high;
        end else if (!SPI_CS) begin
            cs_low++;
        end
        if (SPI_SCK !== prev_sck) sck_edges++;
        if (!prev_cs && SPI_CS) begin
            last_cs_low = cs_low;
            last_edges  = sck_edges;
            cs_high     = 1;
        end else if (SPI_CS) begin
            cs_high++;
        end
        prev_cs  = SPI_CS;
        prev_sck = SPI_SCK;
        if (!HRESETn && (valid || overrun)) check("pulse_in_reset", {valid, overrun}, 0);
        if (valid === 1'b1) begin
            valid_cnt++;
            interval       = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            if (sb.size() == 0) check("valid_unexpected", 1, 0);
            else                check("value", value, sb.pop_front());
        end
        if (overrun === 1'b1) ovr_cnt++;
    end

    task automatic pulse_start();
        start_req = 1'b1;
        @(negedge HCLK);
        start_req = 1'b0;
    endtask

    task automatic wait_valids(input int target, input int limit, input string tag);
        int n = 0;
        while (valid_cnt < target && n < limit) begin
            @(negedge HCLK);
            n++;
        end
        check(tag, valid_cnt >= target, 1);
    endtask

    initial begin
        int n, f0, o0, v0;
        repeat (3) @(negedge HCLK);
        check("rst_cs", SPI_CS, 1);
        check("rst_sck", SPI_SCK, 1);
        check("rst_value", value, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        HRESETn = 1'b1;
        repeat (5) @(negedge HCLK);

        // single shot
        model_data = 8'hA5;
        sb.push_back(8'hA5);
        f0 = frames;
        pulse_start();
        n = 0;
        while (valid !== 1'b1 && n < 2000) begin
            @(negedge HCLK);
            n++;
        end
        check("t2_latency", n, LATENCY);
        check("t2_value", value, 8'hA5);
        repeat (10) @(negedge HCLK);
        check("t2_cs_low", last_cs_low, LATENCY - 1);
        check("t2_sck_edges", last_edges, 32);
        check("t2_frames", frames - f0, 1);
        check("t2_idle_busy", busy, 0);

        // reset mid-shift
        model_data = 8'h77;
        v0 = valid_cnt;
        pulse_start();
        repeat (300) @(negedge HCLK);
        check("t1_busy_before", busy, 1);
        HRESETn = 1'b0;
        #1;
        check("t1_cs", SPI_CS, 1);
        check("t1_sck", SPI_SCK, 1);
        check("t1_value", value, 0);
        check("t1_busy", busy, 0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (1200) @(negedge HCLK);
        check("t1_no_valid", valid_cnt, v0);
        check("t1_cs_idle", SPI_CS, 1);

        // auto mode with a ramping ADC
        model_data = 8'h10;
        ramp = 1'b1;
        sb.push_back(8'h10);
        sb.push_back(8'h11);
        sb.push_back(8'h12);
        v0 = valid_cnt;
        o0 = ovr_cnt;
        auto_en = 1'b1;
        wait_valids(v0 + 1, 2500, "t3_first");
        wait_valids(v0 + 2, 1500, "t3_second");
        check("t3_interval2", interval, SAMPLE_PERIOD);
        wait_valids(v0 + 3, 1500, "t3_third");
        check("t3_interval3", interval, SAMPLE_PERIOD);
        auto_en = 1'b0;
        ramp = 1'b0;
        repeat (1200) @(negedge HCLK);
        check("t3_stopped", valid_cnt, v0 + 3);
        check("t3_overrun", ovr_cnt - o0, 0);

        // overrun: one frame running, then two more requests
        model_data = 8'h3C;
        sb.push_back(8'h3C);
        sb.push_back(8'h3C);
        f0 = frames;
        o0 = ovr_cnt;
        v0 = valid_cnt;
        pulse_start();
        repeat (100) @(negedge HCLK);
        pulse_start();
        repeat (100) @(negedge HCLK);
        pulse_start();
        wait_valids(v0 + 2, 3000, "t4_valids");
        repeat (20) @(negedge HCLK);
        check("t4_frames", frames - f0, 2);
        check("t4_overrun", ovr_cnt - o0, 1);
        check("t4_gap", last_gap, CS_QUIET + 1);

        // start_req coincident with auto terminal count
        model_data = 8'h5A;
        sb.push_back(8'h5A);
        f0 = frames;
        o0 = ovr_cnt;
        v0 = valid_cnt;
        auto_en = 1'b1;
        repeat (SAMPLE_PERIOD - 1) @(negedge HCLK);
        start_req = 1'b1;
        @(negedge HCLK);
        start_req = 1'b0;
        auto_en = 1'b0;
        wait_valids(v0 + 1, 1500, "t5_valid");
        repeat (50) @(negedge HCLK);
        check("t5_frames", frames - f0, 1);
        check("t5_overrun", ovr_cnt - o0, 0);

        // bit order
        model_data = 8'hFF;
        sb.push_back(8'hFF);
        v0 = valid_cnt;
        pulse_start();
        wait_valids(v0 + 1, 1500, "t6_ff_wait");
        check("t6_ff", value, 8'hFF);
        repeat (10) @(negedge HCLK);
        model_data = 8'h01;
        sb.push_back(8'h01);
        pulse_start();
        wait_valids(v0 + 2, 1500, "t6_01_wait");
        check("t6_01", value, 8'h01);
        repeat (10) @(negedge HCLK);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
